mux: RTL and testbench
======================

Name: mux

Overview:
- Parameterised 2:1 word multiplexer for the RISC datapath. Used for ALU operand select, writeback select and PC-source select.
- Primary output `mux_out` is purely combinational, so it can sit inside a single-cycle path.
- A registered copy `mux_out_q` is provided for pipelined users. It uses the shared clock and a synchronous active-high reset.

Parameters:
- MUX_Width, 32, bit width of `in0`, `in1`, `mux_out` and `mux_out_q`. Must be >= 1. Instantiated at 5 in unit benches.

Ports:
- clk, input, 1, system clock; rising edge active.
- rst, input, 1, synchronous active-high reset; affects `mux_out_q` only.
- en, input, 1, load enable for `mux_out_q`.
- sel, input, 1, select: 0 picks `in0`, 1 picks `in1`.
- in0, input, MUX_Width, data input 0.
- in1, input, MUX_Width, data input 1.
- mux_out, output, MUX_Width, combinational selected data.
- mux_out_q, output, MUX_Width, registered selected data.

Behaviour:
Interface:
- One clock; reset is synchronous and active-high (clk, rst).

Combinational path:
- `mux_out` = `in0` when `sel`=0, `in1` when `sel`=1, for every bit.
- Zero-cycle latency. The output settles within the same simulation timestep as an input change; no clock is required.
- `mux_out` is independent of `clk`, `rst` and `en`, and is valid even while `clk` is not toggling or `rst` is held.
- No width extension or truncation; bit i of the output comes from bit i of the selected input.
- The unselected input has no effect on the output: any value, including X/Z, is ignored.
- `sel` = X/Z: output follows standard Verilog conditional-operator semantics. Bits where `in0` and `in1` agree take that value; differing bits are X. No further X-handling is required.

Registered path:
- At each rising edge of `clk`:
  - if `rst`=1: `mux_out_q` <= 0 (all bits), regardless of `en`;
  - else if `en`=1: `mux_out_q` <= `mux_out` value sampled at that edge;
  - else: `mux_out_q` holds.
- Latency is 1 cycle from input to `mux_out_q`.
- Reset value of `mux_out_q` is all zeros. `mux_out` has no reset value because it is combinational.
- `rst` and `en` asserted on the same edge: reset wins.
- `rst` deasserted mid-operation: loading resumes on the first edge where `rst`=0 and `en`=1.
- Before the first reset, `mux_out_q` is X in simulation; no power-on value is guaranteed.

Implementation constraints:
- No latches. The combinational path uses a complete assignment covering both `sel` values.

Test Plan:
1. MUX_Width=5, `sel`=0, `in0`=5'h15, `in1`=5'h00, wait 1 time unit -> `mux_out`=5'h15.
2. `sel`=0, `in0`=5'h0A, `in1`=5'h00 -> `mux_out`=5'h0A. Then `sel`=1, `in0`=5'h00, `in1`=5'h15 -> 5'h15. Then `sel`=1, `in1`=5'h0A -> 5'h0A. Each is checked 1 time unit after the change with no clock running.
3. Unselected input ignored: `sel`=1, `in1`=5'h1F, `in0` driven X -> `mux_out`=5'h1F. `sel`=0, `in0`=5'h00, `in1` driven X -> `mux_out`=5'h00.
4. Reset: `rst`=1 for 2 edges with `en`=1, `sel`=1, `in1`=5'h1F -> `mux_out_q`=5'h00 after the first edge, while `mux_out`=5'h1F throughout.
5. Registered load/hold:
   - `rst`=0, `en`=1, `sel`=0, `in0`=5'h15 -> `mux_out_q`=5'h15 after one edge.
   - Then `en`=0, `in0`=5'h0A -> `mux_out_q` stays 5'h15 over 3 edges while `mux_out`=5'h0A.
6. Exhaustive/random sweep: all `sel` values against 1000 random `in0`/`in1` pairs. `mux_out` must equal the selected input, and `mux_out_q` must equal the previous edge's `mux_out` when `en`=1.

Source files
------------

// File: rtl/mux.sv
// rtl/mux.sv - parameterised 2:1 word multiplexer with combinational and registered outputs
//
// Ports:
//   clk       - system clock, rising edge active
//   rst       - synchronous active-high reset, clears mux_out_q only
//   en        - load enable for mux_out_q
//   sel       - select: 0 picks in0, 1 picks in1
//   in0, in1  - MUX_Width-bit data inputs
//   mux_out   - combinational selected data (zero-cycle latency)
//   mux_out_q - selected data registered on the rising edge of clk

module mux #(
  parameter int MUX_Width = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sel,
  input  logic [MUX_Width-1:0] in0,
  input  logic [MUX_Width-1:0] in1,
  output logic [MUX_Width-1:0] mux_out,
  output logic [MUX_Width-1:0] mux_out_q
);

  logic [MUX_Width-1:0] mux_sel;
  logic [MUX_Width-1:0] mux_out_d;

  // The conditional operator keeps X-select behaviour: bits where both
  // inputs agree pass through, differing bits go X.
  always_comb begin
    mux_sel = sel ? in1 : in0;
  end

  assign mux_out = mux_sel;

  // Hold when not enabled; reset is applied in the flop so it wins over en.
  always_comb begin
    mux_out_d = mux_out_q;
    if (en) begin
      mux_out_d = mux_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mux_out_q <= '0;
    end else begin
      mux_out_q <= mux_out_d;
    end
  end

endmodule

// File: tb/tb_mux.sv
// tb/tb_mux.sv - self-checking bench for mux at MUX_Width=5

module tb_mux;

  localparam int W = 5;

  logic         clk;
  logic         clk_run;
  logic         rst;
  logic         en;
  logic         sel;
  logic [W-1:0] in0;
  logic [W-1:0] in1;
  logic [W-1:0] mux_out;
  logic [W-1:0] mux_out_q;

  int checks;
  int failures;

  // Reference state for the registered output.
  logic [W-1:0] exp_q;
  logic         model_valid;

  mux #(.MUX_Width(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sel      (sel),
    .in0      (in0),
    .in1      (in1),
    .mux_out  (mux_out),
    .mux_out_q(mux_out_q)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  function automatic logic [W-1:0] pick(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    if (s) r = b;
    else   r = a;
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: reset clears, enabled edge captures the selected input, else hold.
  always @(posedge clk) begin
    if (rst) begin
      exp_q       = '0;
      model_valid = 1'b1;
    end else if (en) begin
      exp_q = pick(sel, in0, in1);
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (clk_run && model_valid) begin
      check("cyc_mux_out", mux_out, pick(sel, in0, in1));
      check("cyc_mux_out_q", mux_out_q, exp_q);
    end
  end

  task automatic edge_wait();
    @(posedge clk);
    #2;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    model_valid = 1'b0;
    exp_q       = '0;
    clk_run     = 1'b0;
    rst         = 1'b0;
    en          = 1'b0;
    sel         = 1'b0;
    in0         = '0;
    in1         = '0;

    // Combinational path with no clock.
    sel = 1'b0; in0 = 5'h15; in1 = 5'h00; #1;
    check("comb_sel0_15", mux_out, 5'h15);
    sel = 1'b0; in0 = 5'h0A; in1 = 5'h00; #1;
    check("comb_sel0_0A", mux_out, 5'h0A);
    sel = 1'b1; in0 = 5'h00; in1 = 5'h15; #1;
    check("comb_sel1_15", mux_out, 5'h15);
    sel = 1'b1; in1 = 5'h0A; #1;
    check("comb_sel1_0A", mux_out, 5'h0A);

    // Unselected input carries X.
    sel = 1'b1; in1 = 5'h1F; in0 = 'x; #1;
    check("comb_ign_in0", mux_out, 5'h1F);
    sel = 1'b0; in0 = 5'h00; in1 = 'x; #1;
    check("comb_ign_in1", mux_out, 5'h00);

    // Reset for two edges with en held high.
    in0 = 5'h00; in1 = 5'h1F; sel = 1'b1; en = 1'b1; rst = 1'b1;
    clk_run = 1'b1;
    edge_wait();
    check("rst_edge1_q", mux_out_q, 5'h00);
    check("rst_edge1_out", mux_out, 5'h1F);
    edge_wait();
    check("rst_edge2_q", mux_out_q, 5'h00);
    check("rst_edge2_out", mux_out, 5'h1F);

    // Load then hold.
    rst = 1'b0; en = 1'b1; sel = 1'b0; in0 = 5'h15;
    edge_wait();
    check("load_q", mux_out_q, 5'h15);
    en = 1'b0; in0 = 5'h0A;
    for (int k = 0; k < 3; k++) begin
      edge_wait();
      check("hold_q", mux_out_q, 5'h15);
      check("hold_out", mux_out, 5'h0A);
    end

    // Reset wins over en, then loading resumes once rst drops.
    rst = 1'b1; en = 1'b1; sel = 1'b1; in1 = 5'h0C;
    edge_wait();
    check("rst_wins_q", mux_out_q, 5'h00);
    rst = 1'b0;
    edge_wait();
    check("resume_q", mux_out_q, 5'h0C);

    // Random sweep covering both sel values.
    for (int i = 0; i < 1000; i++) begin
      sel = 1'(i & 1);
      in0 = W'($urandom);
      in1 = W'($urandom);
      en  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 49) == 0);
      edge_wait();
    end

    clk_run = 1'b0;
    #20;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
